// File: rtl/rfnoc_gain_core_if.sv
// Control-port and AXI-Stream signal bundle for the gain core.
// The core takes the slave view; the bench or wrapper takes the master view.
interface rfnoc_gain_core_if;
  logic        ctrlport_req_wr;
  logic        ctrlport_req_rd;
  logic [19:0] ctrlport_req_addr;
  logic [31:0] ctrlport_req_data;
  logic        ctrlport_resp_ack;
  logic [31:0] ctrlport_resp_data;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready;

  modport slave (
    input  ctrlport_req_wr, ctrlport_req_rd, ctrlport_req_addr, ctrlport_req_data,
    output ctrlport_resp_ack, ctrlport_resp_data,
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    input  m_axis_tready
  );

  modport master (
    output ctrlport_req_wr, ctrlport_req_rd, ctrlport_req_addr, ctrlport_req_data,
    input  ctrlport_resp_ack, ctrlport_resp_data,
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tlast, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/rfnoc_gain_core.sv
// I/Q gain datapath: per-lane signed multiply then saturate, 2-stage pipeline,
// with a control-port gain register and read-only NoC ID.
module rfnoc_gain_lane #(
  parameter int VEC_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_adv,
  input  logic signed [VEC_W-1:0] i_gain,
  input  logic signed [VEC_W-1:0] i_x,
  output logic        [VEC_W-1:0] o_y
);
  localparam int PW = 2*VEC_W;
  localparam logic [VEC_W-1:0] SAT_MAX = {1'b0, {(VEC_W-1){1'b1}}};
  localparam logic [VEC_W-1:0] SAT_MIN = {1'b1, {(VEC_W-1){1'b0}}};

  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] r_prod;
  logic                 w_ovf;
  logic [VEC_W-1:0]     w_sat;

  assign w_prod = $signed({{VEC_W{i_gain[VEC_W-1]}}, i_gain}) *
                  $signed({{VEC_W{i_x[VEC_W-1]}}, i_x});

  // Product fits in VEC_W bits only if its top VEC_W+1 bits are all equal.
  assign w_ovf = ~(&r_prod[PW-1:VEC_W-1]) & (|r_prod[PW-1:VEC_W-1]);
  assign w_sat = w_ovf ? (r_prod[PW-1] ? SAT_MIN : SAT_MAX) : r_prod[VEC_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod <= '0;
      o_y    <= '0;
    end else if (i_adv) begin
      r_prod <= w_prod;
      o_y    <= w_sat;
    end
  end
endmodule

module rfnoc_gain_core #(
  parameter logic [19:0] REG_GAIN_ADDR = 20'h0,
  parameter logic [31:0] NOC_ID        = 32'h00000B16
) (
  input  logic              clk,
  input  logic              rst,
  rfnoc_gain_core_if.slave  bus
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 16;
  localparam int STAGES    = 2;
  localparam logic [19:0] NOC_ID_ADDR = REG_GAIN_ADDR + 20'd4;

  typedef struct packed {
    logic        wr;
    logic        rd;
    logic [19:0] addr;
    logic [31:0] data;
  } ctrl_req_t;

  ctrl_req_t   w_req;
  logic [VEC_W-1:0] r_gain;
  logic [VEC_W-1:0] w_gain_nxt;
  logic [31:0] w_rd_data;
  logic        r_ack;
  logic [31:0] r_rdata;

  assign w_req = '{wr:   bus.ctrlport_req_wr,
                   rd:   bus.ctrlport_req_rd,
                   addr: bus.ctrlport_req_addr,
                   data: bus.ctrlport_req_data};

  always_comb begin
    w_gain_nxt = r_gain;
    if (w_req.wr && w_req.addr == REG_GAIN_ADDR)
      w_gain_nxt = w_req.data[VEC_W-1:0];
  end

  // Reads see the post-write gain so a combined rd+wr returns the new value.
  always_comb begin
    w_rd_data = '0;
    if (w_req.addr == REG_GAIN_ADDR)    w_rd_data = {16'h0000, w_gain_nxt};
    else if (w_req.addr == NOC_ID_ADDR) w_rd_data = NOC_ID;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gain  <= 16'h0001;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_gain  <= w_gain_nxt;
      r_ack   <= w_req.wr | w_req.rd;
      r_rdata <= w_req.rd ? w_rd_data : 32'h0;
    end
  end

  assign bus.ctrlport_resp_ack  = r_ack;
  assign bus.ctrlport_resp_data = r_rdata;

  logic                            w_adv;
  logic [STAGES:1]                 r_vld_pipe;
  logic [STAGES:1]                 r_last_pipe;
  logic [NUM_LANES-1:0][VEC_W-1:0] w_in;
  logic [NUM_LANES-1:0][VEC_W-1:0] w_out;

  // Whole pipeline moves together; only a full, unaccepted output stalls it.
  assign w_adv             = !r_vld_pipe[STAGES] || bus.m_axis_tready;
  assign bus.s_axis_tready = w_adv;
  assign w_in              = bus.s_axis_tdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
    end else if (w_adv) begin
      r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], bus.s_axis_tvalid};
      r_last_pipe <= {r_last_pipe[STAGES-1:1], bus.s_axis_tlast};
    end
  end

  // Gain is sampled by stage 1 at acceptance, so later writes leave in-flight items alone.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    rfnoc_gain_lane #(.VEC_W(VEC_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_adv  (w_adv),
      .i_gain (r_gain),
      .i_x    (w_in[l]),
      .o_y    (w_out[l])
    );
  end

  assign bus.m_axis_tdata  = w_out;
  assign bus.m_axis_tvalid = r_vld_pipe[STAGES];
  assign bus.m_axis_tlast  = r_last_pipe[STAGES];
endmodule

// File: tb/tb_rfnoc_gain_core.sv
// Directed and constrained-random checks of the gain core register and datapath.
module tb_rfnoc_gain_core;
  localparam logic [19:0] GADDR = 20'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rfnoc_gain_core_if bus();

  rfnoc_gain_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  function automatic logic [15:0] mdl(input logic [15:0] g, input logic [15:0] x);
    int gi, xi, p;
    gi = $signed(g);
    xi = $signed(x);
    p  = gi * xi;
    if (p > 32767)  return 16'h7FFF;
    if (p < -32768) return 16'h8000;
    return p[15:0];
  endfunction

  task automatic ctrl(input logic wr, input logic rd, input logic [19:0] addr,
                      input logic [31:0] wdata, output logic [31:0] rdata);
    @(negedge clk);
    bus.ctrlport_req_wr   = wr;
    bus.ctrlport_req_rd   = rd;
    bus.ctrlport_req_addr = addr;
    bus.ctrlport_req_data = wdata;
    @(negedge clk);
    bus.ctrlport_req_wr = 1'b0;
    bus.ctrlport_req_rd = 1'b0;
    chk("ack", bus.ctrlport_resp_ack, 1);
    rdata = bus.ctrlport_resp_data;
  endtask

  task automatic set_gain(input logic [15:0] g);
    logic [31:0] rd;
    ctrl(1'b1, 1'b0, GADDR, {16'h0, g}, rd);
  endtask

  task automatic item(input string tag, input logic [31:0] d, input logic [31:0] exp);
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = 1'b1;
    @(negedge clk);
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
    @(negedge clk);
    chk({tag, "_vld"}, bus.m_axis_tvalid, 1);
    chk(tag, {bus.m_axis_tlast, bus.m_axis_tdata}, {1'b1, exp});
  endtask

  initial begin
    logic [31:0] rd;
    logic [32:0] expq[$];
    logic [32:0] outs[$];
    logic [32:0] e;
    logic [32:0] prev_out;
    logic        prev_stall, drop;
    int          sent, rcv, cyc, iv, qv;

    bus.ctrlport_req_wr = 0; bus.ctrlport_req_rd = 0;
    bus.ctrlport_req_addr = '0; bus.ctrlport_req_data = '0;
    bus.s_axis_tdata = '0; bus.s_axis_tlast = 0; bus.s_axis_tvalid = 0;
    bus.m_axis_tready = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_mvld",  bus.m_axis_tvalid, 0);
    chk("rst_mdata", {bus.m_axis_tlast, bus.m_axis_tdata}, 0);
    chk("rst_ack",   bus.ctrlport_resp_ack, 0);
    chk("rst_rdata", bus.ctrlport_resp_data, 0);
    rst = 1'b0;
    #1 chk("rst_srdy", bus.s_axis_tready, 1);

    // Register access
    ctrl(0, 1, GADDR, 0, rd);               chk("rd_gain_rst", rd, 32'h00000001);
    @(negedge clk);
    chk("ack_drop",  bus.ctrlport_resp_ack, 0);
    chk("data_zero", bus.ctrlport_resp_data, 0);
    ctrl(1, 0, GADDR, 32'h12348765, rd);
    ctrl(0, 1, GADDR, 0, rd);               chk("rd_gain_wr", rd, 32'h00008765);
    ctrl(0, 1, GADDR + 20'd4, 0, rd);       chk("rd_nocid", rd, 32'h00000B16);
    ctrl(0, 1, 20'h8, 0, rd);               chk("rd_other", rd, 32'h0);
    ctrl(1, 0, 20'h8, 32'h55, rd);
    ctrl(0, 1, GADDR, 0, rd);               chk("wr_other_ign", rd, 32'h00008765);
    ctrl(1, 1, GADDR, 32'h0000FFFF, rd);    chk("rdwr_post", rd, 32'h0000FFFF);

    // Directed datapath vectors
    set_gain(16'h0001); item("g1",    32'h0005FFFB, 32'h0005FFFB);
    set_gain(16'hFFFF); item("gm1",   32'h0005FFFB, 32'hFFFB0005);
    set_gain(16'h0000); item("g0",    32'h0005FFFB, 32'h00000000);
    set_gain(16'd37);   item("g37",   32'h0064FF38, 32'h0E74E318);
    set_gain(16'hFFEA); item("gm22",  32'hFF0100FF, 32'h15EAEA16);
    set_gain(16'h0100); item("sat",   32'h00FFFF01, 32'h7FFF8000);
    set_gain(16'h8000); item("satmn", 32'h80008000, 32'h7FFF7FFF);

    // Random 64-item packet with stalls on both sides
    set_gain(16'd200);
    sent = 0; rcv = 0; cyc = 0; prev_stall = 0; drop = 0; prev_out = '0;
    while (rcv < 64 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (prev_stall) begin
        chk("hold_vld", bus.m_axis_tvalid, 1);
        chk("hold_data", {bus.m_axis_tlast, bus.m_axis_tdata}, prev_out);
      end
      if (drop) begin bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; drop = 0; end
      bus.m_axis_tready = ($urandom_range(0, 3) != 0);
      if (!bus.s_axis_tvalid && sent < 64 && $urandom_range(0, 3) != 0) begin
        iv = $urandom_range(0, 510); iv -= 255;
        qv = $urandom_range(0, 510); qv -= 255;
        bus.s_axis_tdata  = {16'(iv), 16'(qv)};
        bus.s_axis_tlast  = (sent == 63);
        bus.s_axis_tvalid = 1'b1;
      end
      #1;
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        expq.push_back({bus.s_axis_tlast, mdl(16'd200, bus.s_axis_tdata[31:16]),
                        mdl(16'd200, bus.s_axis_tdata[15:0])});
        sent++;
        drop = 1;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (expq.size() == 0) chk("stream_extra", 1, 0);
        else begin
          e = expq.pop_front();
          chk("stream_item", {bus.m_axis_tlast, bus.m_axis_tdata}, e);
        end
        rcv++;
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_out   = {bus.m_axis_tlast, bus.m_axis_tdata};
    end
    bus.s_axis_tvalid = 0; bus.s_axis_tlast = 0; bus.m_axis_tready = 1;
    chk("stream_cnt", rcv, 64);
    repeat (4) @(negedge clk);
    chk("stream_tail", bus.m_axis_tvalid, 0);

    // Gain change while items flow: write lands with item 4, items 5+ use new gain
    set_gain(16'd3);
    bus.m_axis_tready = 1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (c < 10) begin
        bus.s_axis_tvalid = 1;
        bus.s_axis_tdata  = {16'(c + 1), 16'(-(c + 1))};
        bus.s_axis_tlast  = (c == 9);
      end else begin
        bus.s_axis_tvalid = 0;
        bus.s_axis_tlast  = 0;
      end
      bus.ctrlport_req_wr   = (c == 4);
      bus.ctrlport_req_addr = GADDR;
      bus.ctrlport_req_data = 32'h2;
      #1;
      if (bus.m_axis_tvalid) outs.push_back({bus.m_axis_tlast, bus.m_axis_tdata});
    end
    chk("gchg_cnt", outs.size(), 10);
    for (int c = 0; c < 10 && c < outs.size(); c++)
      chk("gchg_item", outs[c], {c == 9, mdl((c <= 4) ? 16'd3 : 16'd2, 16'(c + 1)),
                                 mdl((c <= 4) ? 16'd3 : 16'd2, 16'(-(c + 1)))});
    if (outs.size() > 5) begin
      chk("gchg_old", outs[4], {1'b0, 32'h000FFFF1});
      chk("gchg_new", outs[5], {1'b0, 32'h000CFFF4});
    end

    // Reset with items in flight
    bus.m_axis_tready = 0;
    @(negedge clk);
    bus.s_axis_tvalid = 1; bus.s_axis_tdata = 32'h00100010;
    repeat (3) @(negedge clk);
    #1 chk("inflight_vld", bus.m_axis_tvalid, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_vld",  bus.m_axis_tvalid, 0);
    chk("rst_mid_data", bus.m_axis_tdata, 0);
    bus.s_axis_tvalid = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("rst_mid_srdy", bus.s_axis_tready, 1);
    ctrl(0, 1, GADDR, 0, rd);                chk("rst_mid_gain", rd, 32'h00000001);
    bus.m_axis_tready = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_no_stale", bus.m_axis_tvalid, 0);
    end
    item("post_rst", 32'h0005FFFB, 32'h0005FFFB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end
endmodule
